// File: rtl/adc_frame_pkg.sv
// ---------------------------------------------------------------------------
// adc_frame_pkg
// Shared types and helpers for the ADC frame packer.
//   FRAME_MAGIC     : tag byte leading every header word
//   framer_state_t  : one-hot framer states (IDLE, ARM, FILL, DROP)
//   build_header()  : {FRAME_MAGIC, channel id, frame counter}
//   build_data()    : two 12-bit samples zero-padded into one 32-bit word
// ---------------------------------------------------------------------------
package adc_frame_pkg;

    localparam logic [7:0] FRAME_MAGIC = 8'hA5;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ARM  = 4'b0010,
        FILL = 4'b0100,
        DROP = 4'b1000
    } framer_state_t;

    function automatic logic [31:0] build_header(input logic [7:0]  ch,
                                                 input logic [15:0] cnt);
        return {FRAME_MAGIC, ch, cnt};
    endfunction

    // The earlier sample sits in the low half of the word.
    function automatic logic [31:0] build_data(input logic [11:0] s_odd,
                                               input logic [11:0] s_even);
        return {4'h0, s_odd, 4'h0, s_even};
    endfunction

endpackage

// File: rtl/adc_stream_fifo.sv
// ---------------------------------------------------------------------------
// adc_stream_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always present
// on pop_data; a word written in cycle N becomes visible in cycle N+1.
// Ports:
//   clk, srst          : clock, synchronous active-high reset (flushes FIFO)
//   push, push_data    : write request / data
//   pop                : consume the head entry (ignored while empty)
//   pop_data           : head entry
//   empty              : no entries stored
//   count              : registered number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module adc_stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign count = count_reg;

    // A push into a full FIFO is accepted when the head is popped in the same
    // cycle: the write lands in the slot being vacated.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale contents are never visible because the
    // consumer qualifies pop_data with !empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/adc_frame_packer.sv
// ---------------------------------------------------------------------------
// adc_frame_packer
// Packs a 12-bit ADC sample stream two-per-word into fixed-length frames led
// by a header word and emits them on an AXI-Stream master through a FIFO.
// A frame is admitted only if the FIFO can hold all of it, so only whole
// frames are ever emitted; frames that do not fit are counted and dropped.
//
// Optional build macro: ADC_FRAME_TEST_PATTERN_EN adds input test_mode, which
// replaces sample_in with a 12-bit ramp advancing on every sample_valid_in.
//
// Ports:
//   data_in_clk      : sole clock
//   rst              : synchronous active-high reset
//   enable           : frames start only while high
//   test_mode        : (optional) select ramp pattern instead of sample_in
//   sample_in        : 12-bit sample
//   sample_valid_in  : sample strobe, may be high every cycle
//   m_axis_tdata     : header or data word
//   m_axis_tvalid    : FIFO not empty
//   m_axis_tready    : sink ready
//   m_axis_tlast     : last data word of a frame
//   frame_count      : frames admitted (wraps)
//   drop_count       : frames dropped (saturates)
//   busy             : framer in FILL or DROP
// ---------------------------------------------------------------------------
module adc_frame_packer
    import adc_frame_pkg::*;
#(
    parameter int         FRAME_LEN  = 64,
    parameter int         FIFO_DEPTH = 64,
    parameter logic [7:0] CHANNEL_ID = 8'd0
) (
    input  logic        data_in_clk,
    input  logic        rst,
    input  logic        enable,
`ifdef ADC_FRAME_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [11:0] sample_in,
    input  logic        sample_valid_in,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic        busy
);

    localparam int CNT_W        = $clog2(FRAME_LEN) + 1;
    localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int WORDS_NEEDED = FRAME_LEN / 2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    framer_state_t     state_reg;
    framer_state_t     state_next;
    logic [CNT_W-1:0]  sample_cnt_reg;
    logic [11:0]       s_even_reg;
    logic [15:0]       frame_count_reg;
    logic [15:0]       drop_count_reg;

    logic [11:0]       sample_sel;
    logic              last_sample;
    logic              admit_ok;
    logic [FCNT_W-1:0] fifo_count;
    logic [FCNT_W-1:0] free_slots;
    logic              fifo_empty;
    logic              fifo_push;
    logic [32:0]       fifo_wdata;
    logic [32:0]       fifo_rdata;
    logic              frame_start;
    logic              drop_start;

    // -----------------------------------------------------------------------
    // Sample source
    // -----------------------------------------------------------------------
`ifdef ADC_FRAME_TEST_PATTERN_EN
    logic [11:0] ramp_reg;

    always_ff @(posedge data_in_clk) begin
        if (rst) begin
            ramp_reg <= '0;
        end else if (sample_valid_in) begin
            ramp_reg <= ramp_reg + 12'd1;
        end
    end

    assign sample_sel = test_mode ? ramp_reg : sample_in;
`else
    assign sample_sel = sample_in;
`endif

    // -----------------------------------------------------------------------
    // Admission: free space from the registered count only. A pop in the same
    // cycle is ignored, which can only make the check stricter.
    // -----------------------------------------------------------------------
    assign free_slots  = FCNT_W'(FIFO_DEPTH) - fifo_count;
    assign admit_ok    = (free_slots >= FCNT_W'(WORDS_NEEDED));
    assign last_sample = (sample_cnt_reg == LAST_IDX);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge data_in_clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (sample_valid_in) begin
                    state_next = admit_ok ? FILL : DROP;
                end
            end
            FILL, DROP: begin
                // A frame always runs to completion once started, even if
                // enable falls part-way through.
                if (sample_valid_in && last_sample) begin
                    state_next = enable ? ARM : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (FIFO write port and frame start strobes)
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_push   = 1'b0;
        fifo_wdata  = '0;
        frame_start = 1'b0;
        drop_start  = 1'b0;
        unique case (state_reg)
            ARM: begin
                if (enable && sample_valid_in) begin
                    if (admit_ok) begin
                        frame_start = 1'b1;
                        fifo_push   = 1'b1;
                        fifo_wdata  = {1'b0, build_header(CHANNEL_ID, frame_count_reg)};
                    end else begin
                        drop_start  = 1'b1;
                    end
                end
            end
            FILL: begin
                // Odd sample index completes a pair. Header goes out on sample
                // 0, so there is never more than one push per cycle, and
                // admission already reserved space for every data word.
                if (sample_valid_in && sample_cnt_reg[0]) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {last_sample, build_data(sample_sel, s_even_reg)};
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: sample counter, even-sample latch, frame/drop counters.
    // sample_cnt_reg holds the number of samples of the current frame already
    // consumed; sample 0 is consumed in ARM, so a frame start loads 1.
    // -----------------------------------------------------------------------
    always_ff @(posedge data_in_clk) begin
        if (rst) begin
            sample_cnt_reg  <= '0;
            s_even_reg      <= '0;
            frame_count_reg <= '0;
            drop_count_reg  <= '0;
        end else begin
            if (frame_start) begin
                sample_cnt_reg  <= CNT_W'(1);
                s_even_reg      <= sample_sel;
                frame_count_reg <= frame_count_reg + 16'd1;
            end
            if (drop_start) begin
                sample_cnt_reg <= CNT_W'(1);
                if (drop_count_reg != 16'hFFFF) begin
                    drop_count_reg <= drop_count_reg + 16'd1;
                end
            end
            if ((state_reg == FILL || state_reg == DROP) && sample_valid_in) begin
                sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
                if (state_reg == FILL && !sample_cnt_reg[0]) begin
                    s_even_reg <= sample_sel;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO: bit 32 carries tlast
    // -----------------------------------------------------------------------
    adc_stream_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (data_in_clk),
        .srst      (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (m_axis_tvalid && m_axis_tready),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Data is forced to zero while nothing is queued so the bus reads 0 after
    // reset regardless of stale storage contents.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_rdata[31:0] : 32'd0;
    assign m_axis_tlast  = m_axis_tvalid ? fifo_rdata[32]   : 1'b0;

    assign frame_count = frame_count_reg;
    assign drop_count  = drop_count_reg;
    assign busy        = (state_reg == FILL) || (state_reg == DROP);

endmodule

// File: tb/tb_adc_frame_packer.sv
module tb_adc_frame_packer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        en2 = 1'b0;
    logic        test_mode = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid_in = 1'b0;
    logic        tready = 1'b1;

    logic [31:0] td1, td2;
    logic        tv1, tv2, tl1, tl2, busy1, busy2;
    logic [15:0] fc1, fc2, dc1, dc2;

    int total = 0;
    int bad   = 0;

    logic [32:0] q1[$];
    logic [32:0] q2[$];

    // Main DUT: 4-sample frames, tight 4-word FIFO.
    adc_frame_packer #(
        .FRAME_LEN  (4),
        .FIFO_DEPTH (4),
        .CHANNEL_ID (8'h00)
    ) u_dut (
        .data_in_clk     (clk),
        .rst             (rst),
        .enable          (enable),
`ifdef ADC_FRAME_TEST_PATTERN_EN
        .test_mode       (test_mode),
`endif
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .m_axis_tdata    (td1),
        .m_axis_tvalid   (tv1),
        .m_axis_tready   (tready),
        .m_axis_tlast    (tl1),
        .frame_count     (fc1),
        .drop_count      (dc1),
        .busy            (busy1)
    );

    // Second DUT: 2-sample frames, non-zero channel id, sink always ready.
    adc_frame_packer #(
        .FRAME_LEN  (2),
        .FIFO_DEPTH (4),
        .CHANNEL_ID (8'h3C)
    ) u_dut2 (
        .data_in_clk     (clk),
        .rst             (rst),
        .enable          (en2),
`ifdef ADC_FRAME_TEST_PATTERN_EN
        .test_mode       (test_mode),
`endif
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .m_axis_tdata    (td2),
        .m_axis_tvalid   (tv2),
        .m_axis_tready   (1'b1),
        .m_axis_tlast    (tl2),
        .frame_count     (fc2),
        .drop_count      (dc2),
        .busy            (busy2)
    );

    // Capture every accepted beat, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (tv1 && tready) q1.push_back({tl1, td1});
        if (tv2)           q2.push_back({tl2, td2});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Compare captured word idx of stream 1 or 2 with {tlast, tdata}.
    task automatic check_word(input string tag, input int which, input int idx, input logic [32:0] exp);
        logic [32:0] got;
        got = 33'h1_FFFF_FFFF;
        if (which == 1) begin
            if (idx < q1.size()) got = q1[idx];
        end else begin
            if (idx < q2.size()) got = q2[idx];
        end
        check(tag, 64'(got), 64'(exp));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [11:0] s);
        sample_in       = s;
        sample_valid_in = 1'b1;
        tick(1);
        sample_valid_in = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_tvalid", 64'(tv1), 64'(0));
        check("rst_tdata",  64'(td1), 64'(0));
        check("rst_fc",     64'(fc1), 64'(0));
        check("rst_dc",     64'(dc1), 64'(0));
        check("rst_busy",   64'(busy1), 64'(0));
        rst = 1'b0;

        // Test 1: one frame, sink always ready
        enable = 1'b1;
        tick(1);
        for (int i = 1; i <= 4; i++) drive(12'(i));
        tick(5);
        check("t1_nwords", 64'(q1.size()), 64'(3));
        check_word("t1_w0", 1, 0, 33'h0_A500_0000);
        check_word("t1_w1", 1, 1, 33'h0_0002_0001);
        check_word("t1_w2", 1, 2, 33'h1_0004_0003);
        check("t1_fc", 64'(fc1), 64'(1));
        check("t1_dc", 64'(dc1), 64'(0));
        q1.delete();

        // Test 2: sink stalled, second frame cannot fit and is dropped
        tready = 1'b0;
        for (int i = 0; i < 8; i++) drive(12'(16 + i));
        tick(2);
        check("t2_dc",       64'(dc1), 64'(1));
        check("t2_fc",       64'(fc1), 64'(2));
        check("t2_tvalid",   64'(tv1), 64'(1));
        check("t2_hold_dat", 64'(td1), 64'h0000_0000_A500_0001);
        check("t2_hold_lst", 64'(tl1), 64'(0));
        check("t2_busy",     64'(busy1), 64'(0));
        tready = 1'b1;
        tick(6);
        check("t2_nwords", 64'(q1.size()), 64'(3));
        check_word("t2_w0", 1, 0, 33'h0_A500_0001);
        check_word("t2_w1", 1, 1, 33'h0_0011_0010);
        check_word("t2_w2", 1, 2, 33'h1_0013_0012);
        check("t2_empty", 64'(tv1), 64'(0));
        q1.delete();

        // Test 3: enable falls mid-frame; frame completes, later samples ignored
        drive(12'h100);
        drive(12'h101);
        enable = 1'b0;
        drive(12'h102);
        drive(12'h103);
        drive(12'h104);
        drive(12'h105);
        tick(5);
        check("t3_nwords", 64'(q1.size()), 64'(3));
        check_word("t3_w0", 1, 0, 33'h0_A500_0002);
        check_word("t3_w1", 1, 1, 33'h0_0101_0100);
        check_word("t3_w2", 1, 2, 33'h1_0103_0102);
        check("t3_fc",   64'(fc1), 64'(3));
        check("t3_busy", 64'(busy1), 64'(0));
        q1.delete();

        // Test 4: reset mid-FILL with the header queued
        tready = 1'b0;
        enable = 1'b1;
        tick(1);
        drive(12'h200);
        tick(1);
        check("t4_pre_tvalid", 64'(tv1), 64'(1));
        check("t4_pre_busy",   64'(busy1), 64'(1));
        check("t4_pre_hdr",    64'(td1), 64'h0000_0000_A500_0003);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t4_tvalid", 64'(tv1), 64'(0));
        check("t4_fc",     64'(fc1), 64'(0));
        check("t4_dc",     64'(dc1), 64'(0));
        check("t4_busy",   64'(busy1), 64'(0));
        tready = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) drive(12'h300 + 12'(i));
        tick(5);
        check("t4_nwords", 64'(q1.size()), 64'(3));
        check_word("t4_w0", 1, 0, 33'h0_A500_0000);
        check_word("t4_w1", 1, 1, 33'h0_0301_0300);
        check_word("t4_w2", 1, 2, 33'h1_0303_0302);
        q1.delete();

        // Test 5: 2-sample frames with channel id 0x3C on the second DUT
        enable = 1'b0;
        tick(1);
        en2 = 1'b1;
        tick(1);
        drive(12'hABC);
        drive(12'h123);
        drive(12'h456);
        drive(12'h789);
        tick(5);
        check("t5_nwords", 64'(q2.size()), 64'(4));
        check_word("t5_w0", 2, 0, 33'h0_A53C_0000);
        check_word("t5_w1", 2, 1, 33'h1_0123_0ABC);
        check_word("t5_w2", 2, 2, 33'h0_A53C_0001);
        check_word("t5_w3", 2, 3, 33'h1_0789_0456);
        check("t5_fc2", 64'(fc2), 64'(2));
        check("t5_main_idle", 64'(q1.size()), 64'(0));

`ifdef ADC_FRAME_TEST_PATTERN_EN
        // Test 6: ramp pattern replaces sample_in
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q1.delete();
        test_mode = 1'b1;
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) drive(12'hFFF);
        tick(5);
        check("t6_nwords", 64'(q1.size()), 64'(3));
        check_word("t6_w0", 1, 0, 33'h0_A500_0000);
        check_word("t6_w1", 1, 1, 33'h0_0001_0000);
        check_word("t6_w2", 1, 2, 33'h1_0003_0002);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
